// File: rtl/reset_sequencer.sv
// reset_sequencer: lock-qualified, glitch-filtered, staggered core/peripheral reset generator
module reset_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_locked,
  input  logic       i_sw_rst,
  output logic       o_rst,
  output logic       o_rst_periph,
  output logic       o_ready,
  output logic [7:0] o_lock_loss_cnt
);
  localparam int MAXC = HOLD_CYCLES > STAGGER_CYCLES ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CW = $clog2(MAXC) + 1;
  typedef enum logic [1:0] {WAIT_LOCK, HOLD, CORE, RUN} state_t;
  state_t r_state, w_state_nxt;
  logic [1:0] r_rst_sync;
  logic w_rst_n;
  logic [SYNC_STAGES-1:0] r_lock_sync;
  logic w_locked_s;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_loss_cnt;
  logic w_loss;
  logic r_rst, r_rst_periph, r_ready;
  logic w_rst_nxt, w_rst_periph_nxt, w_ready_nxt;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_rst_sync <= '0;
    else r_rst_sync <= {r_rst_sync[0], 1'b1};
  assign w_rst_n = r_rst_sync[1];
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_lock_sync <= '0;
    else r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], i_locked};
  assign w_locked_s = r_lock_sync[SYNC_STAGES-1];
  // w_rst_n drops asynchronously with i_rst_n but rises only after the two-flop chain
  always_ff @(posedge i_clk or negedge w_rst_n)
    if (!w_rst_n) begin
      r_state      <= WAIT_LOCK;
      r_cnt        <= '0;
      r_loss_cnt   <= '0;
      r_rst        <= 1'b1;
      r_rst_periph <= 1'b1;
      r_ready      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_loss_cnt   <= (w_loss && r_loss_cnt != 8'hFF) ? r_loss_cnt + 8'd1 : r_loss_cnt;
      r_rst        <= w_rst_nxt;
      r_rst_periph <= w_rst_periph_nxt;
      r_ready      <= w_ready_nxt;
    end
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_loss      = 1'b0;
    case (r_state)
      WAIT_LOCK: w_state_nxt = w_locked_s ? HOLD : WAIT_LOCK;
      HOLD: begin
        w_state_nxt = !w_locked_s ? WAIT_LOCK : (r_cnt == CW'(HOLD_CYCLES-1)) ? CORE : HOLD;
        w_cnt_nxt   = (w_state_nxt == HOLD) ? r_cnt + CW'(1) : '0;
      end
      CORE: begin
        w_loss      = !w_locked_s;
        w_state_nxt = !w_locked_s ? WAIT_LOCK : i_sw_rst ? HOLD :
                      (r_cnt == CW'(STAGGER_CYCLES-1)) ? RUN : CORE;
        w_cnt_nxt   = (w_state_nxt == CORE) ? r_cnt + CW'(1) : '0;
      end
      default: begin
        w_loss      = !w_locked_s;
        w_state_nxt = !w_locked_s ? WAIT_LOCK : i_sw_rst ? HOLD : RUN;
      end
    endcase
  end
  always_comb begin
    w_rst_nxt        = (w_state_nxt == WAIT_LOCK) || (w_state_nxt == HOLD);
    w_rst_periph_nxt = w_state_nxt != RUN;
    w_ready_nxt      = w_state_nxt == RUN;
  end
  assign o_rst           = r_rst;
  assign o_rst_periph    = r_rst_periph;
  assign o_ready         = r_ready;
  assign o_lock_loss_cnt = r_loss_cnt;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed self-checking bench for reset_sequencer
module tb_reset_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic locked = 1'b1;
  logic sw_rst = 1'b0;
  logic o_rst, o_rst_periph, o_ready;
  logic [7:0] cnt;
  int vectors = 0;
  int miscompares = 0;
  reset_sequencer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_locked(locked), .i_sw_rst(sw_rst),
    .o_rst(o_rst), .o_rst_periph(o_rst_periph), .o_ready(o_ready), .o_lock_loss_cnt(cnt)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic outs(input string tag, input logic r, input logic p, input logic rd, input logic [7:0] c);
    check({tag, ".rst"}, 32'(o_rst), 32'(r));
    check({tag, ".periph"}, 32'(o_rst_periph), 32'(p));
    check({tag, ".ready"}, 32'(o_ready), 32'(rd));
    check({tag, ".cnt"}, 32'(cnt), 32'(c));
  endtask
  task automatic loss_cycle();
    locked = 1'b1;
    step(20);
    locked = 1'b0;
    step(3);
  endtask
  initial begin
    step(5);
    outs("por_hold", 1, 1, 0, 0);
    rst_n = 1'b1;
    step(18);
    outs("por_e18", 1, 1, 0, 0);
    step(1);
    outs("por_e19", 0, 1, 0, 0);
    step(3);
    outs("por_e22", 0, 1, 0, 0);
    step(1);
    outs("por_e23", 0, 0, 1, 0);
    locked = 1'b0;
    step(2);
    outs("loss_e2", 0, 0, 1, 0);
    step(1);
    outs("loss_e3", 1, 1, 0, 1);
    locked = 1'b1;
    step(18);
    outs("requal_e18", 1, 1, 0, 1);
    step(1);
    outs("requal_e19", 0, 1, 0, 1);
    step(4);
    outs("requal_e23", 0, 0, 1, 1);
    locked = 1'b0;
    step(3);
    outs("pre_glitch", 1, 1, 0, 2);
    locked = 1'b1;
    step(10);
    locked = 1'b0;
    step(1);
    locked = 1'b1;
    step(8);
    outs("glitch_e19", 1, 1, 0, 2);
    step(10);
    outs("glitch_e29", 1, 1, 0, 2);
    step(1);
    outs("glitch_e30", 0, 1, 0, 2);
    step(4);
    outs("glitch_e34", 0, 0, 1, 2);
    sw_rst = 1'b1;
    step(1);
    sw_rst = 1'b0;
    outs("sw_e1", 1, 1, 0, 2);
    step(15);
    outs("sw_e16", 1, 1, 0, 2);
    step(1);
    outs("sw_e17", 0, 1, 0, 2);
    step(3);
    outs("sw_e20", 0, 1, 0, 2);
    step(1);
    outs("sw_e21", 0, 0, 1, 2);
    locked = 1'b0;
    step(2);
    sw_rst = 1'b1;
    step(1);
    sw_rst = 1'b0;
    outs("prio", 1, 1, 0, 3);
    step(3);
    outs("prio_wait", 1, 1, 0, 3);
    repeat (251) loss_cycle();
    check("sat_254", 32'(cnt), 254);
    loss_cycle();
    check("sat_255", 32'(cnt), 255);
    repeat (48) loss_cycle();
    check("sat_hold", 32'(cnt), 255);
    locked = 1'b1;
    step(23);
    outs("run_again", 0, 0, 1, 255);
    #2 rst_n = 1'b0;
    #1 outs("async_rst", 1, 1, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(18);
    outs("rel_e18", 1, 1, 0, 0);
    step(1);
    outs("rel_e19", 0, 1, 0, 0);
    step(4);
    outs("rel_e23", 0, 0, 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
